// File: rtl/read_route_ctrl_if.sv
// Handshake and status bundle between the AR decoder / R datapath and read_route_ctrl.
// The controller connects through the slave modport; the surrounding fabric uses master.
interface read_route_ctrl_if #(
   parameter int unsigned MAX_OUTSTANDING = 4
);
   localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING) + 1;

   logic             ar_fire;
   logic [1:0]       ar_slave_sel;
   logic             ar_accept_ok;
   logic             r_route_valid;
   logic [1:0]       r_sel;
   logic             r_fire;
   logic             r_last;
   logic             r_in_burst;
   logic [7:0]       r_beat_cnt;
   logic [CNT_W-1:0] outstanding;
   logic             err_overflow;
   logic             err_unexpected_r;

   modport master (
      output ar_fire, ar_slave_sel, r_fire, r_last,
      input  ar_accept_ok, r_route_valid, r_sel, r_in_burst, r_beat_cnt, outstanding,
             err_overflow, err_unexpected_r
   );

   modport slave (
      input  ar_fire, ar_slave_sel, r_fire, r_last,
      output ar_accept_ok, r_route_valid, r_sel, r_in_burst, r_beat_cnt, outstanding,
             err_overflow, err_unexpected_r
   );
endinterface

// File: rtl/read_route_ctrl.sv
// In-order read route queue: remembers the slave of each accepted AR and steers the R
// return mux / RREADY demux to that slave until the burst's RLAST beat completes.
module read_route_ctrl #(
   parameter int unsigned MAX_OUTSTANDING = 4
) (
   input logic              ACLK,
   input logic              ARESET,
   read_route_ctrl_if.slave bus
);
   localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING) + 1;
   localparam int unsigned PTR_W = $clog2(MAX_OUTSTANDING);

   typedef enum logic [1:0] {StIdle, StRoute, StBurst} state_e;

   state_e           state_q, state_d;
   logic [1:0]       mem_q [MAX_OUTSTANDING];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [7:0]       beat_q, beat_d;
   logic             ovf_q, ovf_d;
   logic             unexp_q, unexp_d;

   logic full, empty, push, pop;

   assign full  = (count_q == CNT_W'(MAX_OUTSTANDING));
   assign empty = (count_q == '0);
   // A full queue drops the AR even when a pop frees a slot in the same cycle.
   assign push  = bus.ar_fire & ~full;
   assign pop   = bus.r_fire & bus.r_last & ~empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      beat_d   = beat_q;
      ovf_d    = bus.ar_fire & full;
      unexp_d  = bus.r_fire & empty;

      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

      unique case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      if (pop) begin
         beat_d = 8'd0;
      end else if (bus.r_fire && !empty && beat_q != 8'hFF) begin
         beat_d = beat_q + 8'd1;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (push) state_d = StRoute;
         end
         StRoute, StBurst: begin
            if (pop) begin
               state_d = (count_d != '0) ? StRoute : StIdle;
            end else if (bus.r_fire) begin
               state_d = StBurst;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state_q  <= StIdle;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         beat_q   <= 8'd0;
         ovf_q    <= 1'b0;
         unexp_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         beat_q   <= beat_d;
         ovf_q    <= ovf_d;
         unexp_q  <= unexp_d;
      end
   end

   // Entry storage needs no reset: it is only observed while count is non-zero.
   always_ff @(posedge ACLK) begin
      if (!ARESET && push) mem_q[wr_ptr_q] <= bus.ar_slave_sel;
   end

   assign bus.ar_accept_ok     = ~full;
   assign bus.r_route_valid    = (state_q != StIdle);
   assign bus.r_in_burst       = (state_q == StBurst);
   assign bus.r_sel            = empty ? 2'b00 : mem_q[rd_ptr_q];
   assign bus.r_beat_cnt       = beat_q;
   assign bus.outstanding      = count_q;
   assign bus.err_overflow     = ovf_q;
   assign bus.err_unexpected_r = unexp_q;
endmodule

// File: tb/tb_read_route_ctrl.sv
// Directed and randomized bench for read_route_ctrl against a queue-based reference model.
module tb_read_route_ctrl;
   localparam int unsigned MAXO = 4;

   logic ACLK = 1'b0;
   logic ARESET = 1'b1;

   read_route_ctrl_if #(.MAX_OUTSTANDING(MAXO)) bus ();

   read_route_ctrl #(.MAX_OUTSTANDING(MAXO)) dut (
      .ACLK   (ACLK),
      .ARESET (ARESET),
      .bus    (bus)
   );

   always #5 ACLK = ~ACLK;

   int n_checks = 0;
   int n_errors = 0;

   logic [1:0]  m_q [$];
   int unsigned m_beats = 0;
   bit          m_ovf = 0;
   bit          m_unexp = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      int sz;
      sz = m_q.size();
      chk({tag, ".outstanding"}, 32'(bus.outstanding), 32'(sz));
      chk({tag, ".route_valid"}, 32'(bus.r_route_valid), 32'(sz > 0));
      chk({tag, ".r_sel"}, 32'(bus.r_sel), (sz > 0) ? 32'(m_q[0]) : 32'd0);
      chk({tag, ".in_burst"}, 32'(bus.r_in_burst), 32'(sz > 0 && m_beats > 0));
      chk({tag, ".beat_cnt"}, 32'(bus.r_beat_cnt), 32'(m_beats));
      chk({tag, ".accept_ok"}, 32'(bus.ar_accept_ok), 32'(sz < int'(MAXO)));
      chk({tag, ".err_ovf"}, 32'(bus.err_overflow), 32'(m_ovf));
      chk({tag, ".err_unexp"}, 32'(bus.err_unexpected_r), 32'(m_unexp));
   endtask

   // One clock: apply inputs, advance the model by the transaction rules, compare.
   task automatic cyc(input string tag, input bit ar, input logic [1:0] sel,
                      input bit rf, input bit rl);
      bit was_full, was_empty;
      bus.ar_fire = ar;
      bus.ar_slave_sel = sel;
      bus.r_fire = rf;
      bus.r_last = rl;
      @(posedge ACLK);
      #1;
      was_full  = (m_q.size() == int'(MAXO));
      was_empty = (m_q.size() == 0);
      m_ovf   = ar && was_full;
      m_unexp = rf && was_empty;
      if (rf && !was_empty) begin
         if (rl) begin
            void'(m_q.pop_front());
            m_beats = 0;
         end else if (m_beats < 255) begin
            m_beats++;
         end
      end
      if (ar && !was_full) m_q.push_back(sel);
      check_all(tag);
   endtask

   task automatic do_reset(input string tag);
      ARESET = 1'b1;
      bus.ar_fire = 1'b1;
      bus.ar_slave_sel = 2'd3;
      bus.r_fire = 1'b1;
      bus.r_last = 1'b1;
      @(posedge ACLK);
      #1;
      m_q.delete();
      m_beats = 0;
      m_ovf = 0;
      m_unexp = 0;
      check_all(tag);
      ARESET = 1'b0;
   endtask

   initial begin
      bus.ar_fire = 1'b0;
      bus.ar_slave_sel = 2'd0;
      bus.r_fire = 1'b0;
      bus.r_last = 1'b0;

      do_reset("reset");
      cyc("idle", 0, 0, 0, 0);

      // Single 4-beat read to slave 2
      cyc("single.ar", 1, 2'd2, 0, 0);
      cyc("single.b1", 0, 0, 1, 0);
      cyc("single.b2", 0, 0, 1, 0);
      cyc("single.b3", 0, 0, 1, 0);
      cyc("single.b4", 0, 0, 1, 1);

      // Ordering: fill, then back-to-back single-beat pops
      cyc("order.p3", 1, 2'd3, 0, 0);
      cyc("order.p1", 1, 2'd1, 0, 0);
      cyc("order.p0", 1, 2'd0, 0, 0);
      cyc("order.p2", 1, 2'd2, 0, 0);
      for (int i = 0; i < 4; i++) cyc("order.pop", 0, 0, 1, 1);

      // Overflow with simultaneous last beat
      cyc("ovf.f0", 1, 2'd0, 0, 0);
      cyc("ovf.f1", 1, 2'd2, 0, 0);
      cyc("ovf.f2", 1, 2'd3, 0, 0);
      cyc("ovf.f3", 1, 2'd0, 0, 0);
      cyc("ovf.hit", 1, 2'd1, 1, 1);
      cyc("ovf.after", 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) cyc("ovf.drain", 0, 0, 1, 1);

      // Simultaneous push/pop at count 1
      cyc("pp.p0", 1, 2'd0, 0, 0);
      cyc("pp.both", 1, 2'd3, 1, 1);
      cyc("pp.drain", 0, 0, 1, 1);

      // Unexpected R while empty
      cyc("unexp.hit", 0, 0, 1, 1);
      cyc("unexp.after", 0, 0, 0, 0);

      // Reset mid-burst
      cyc("rmb.p2", 1, 2'd2, 0, 0);
      cyc("rmb.p1", 1, 2'd1, 0, 0);
      cyc("rmb.b1", 0, 0, 1, 0);
      cyc("rmb.b2", 0, 0, 1, 0);
      do_reset("rmb.reset");
      cyc("rmb.ar1", 1, 2'd1, 0, 0);
      cyc("rmb.last", 0, 0, 1, 1);

      // Beat counter saturation on a very long burst
      cyc("sat.ar", 1, 2'd3, 0, 0);
      for (int i = 0; i < 260; i++) cyc("sat.beat", 0, 0, 1, 0);
      cyc("sat.last", 0, 0, 1, 1);

      // Randomized traffic with occasional resets
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(99) == 0) begin
            do_reset("rnd.reset");
         end else begin
            cyc("rnd", ($urandom_range(99) < 45), 2'($urandom_range(3)),
                ($urandom_range(99) < 50), ($urandom_range(99) < 40));
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
